// File: rtl/arm_pkg.sv
// arm_pkg: shared angle type, default limits, clamp helper and controller state enum
package arm_pkg;
  typedef logic [31:0] angle_t;
  localparam angle_t ANG_MIN_DEF = 32'h0000_0000;
  localparam angle_t ANG_MAX_DEF = 32'h00B4_0000;
  localparam angle_t HOME_DEF = 32'h005A_0000;
  typedef enum logic {IDLE, MOVE} state_e;
  // Returns {out_of_range, clamped value}
  function automatic logic [32:0] clamp(angle_t v, angle_t lo, angle_t hi);
    return v < lo ? {1'b1, lo} : v > hi ? {1'b1, hi} : {1'b0, v};
  endfunction
endpackage

// File: rtl/arm_joint_ctrl_if.sv
// arm_joint_ctrl_if: target sources in, commanded angles and status out
interface arm_joint_ctrl_if #(parameter int N_JOINTS = 2, parameter int W = 32);
  logic en_inv, inv_valid, en_set, moving, clamped;
  logic [N_JOINTS*W-1:0] inv_angles, set_angles, angles, target;
  modport master(output en_inv, inv_valid, inv_angles, en_set, set_angles,
                 input angles, target, moving, clamped);
  modport slave(input en_inv, inv_valid, inv_angles, en_set, set_angles,
                output angles, target, moving, clamped);
endinterface

// File: rtl/joint_slew.sv
// joint_slew: one joint's commanded angle, stepping toward target by at most STEP per tick
module joint_slew #(
  parameter int W = 32,
  parameter logic [W-1:0] HOME = 32'h005A_0000,
  parameter logic [W-1:0] STEP = 32'h0000_8000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_i,
  input  logic [W-1:0] target_i,
  output logic [W-1:0] angle_o,
  output logic         at_target_o
);
  logic [W-1:0] angle_q, angle_d;
  logic [W:0] diff;
  logic up;
  // Distance is taken in W+1 bits so a full-scale gap never wraps
  always_comb begin
    up = target_i > angle_q;
    diff = up ? {1'b0, target_i} - {1'b0, angle_q} : {1'b0, angle_q} - {1'b0, target_i};
    angle_d = !tick_i ? angle_q : diff <= {1'b0, STEP} ? target_i : up ? angle_q + STEP : angle_q - STEP;
  end
  // Commanded angle register
  always_ff @(posedge clk or posedge rst)
    if (rst) angle_q <= HOME;
    else angle_q <= angle_d;
  assign angle_o = angle_q;
  assign at_target_o = angle_q == target_i;
endmodule

// File: rtl/arm_joint_ctrl.sv
// arm_joint_ctrl: N-joint target select, clamp and slew; ARM_SLEW_EN enables rate-limited slewing
module arm_joint_ctrl import arm_pkg::*; #(
  parameter int N_JOINTS = 2,
  parameter int W = 32,
  parameter angle_t ANG_MIN = ANG_MIN_DEF,
  parameter angle_t ANG_MAX = ANG_MAX_DEF,
  parameter angle_t HOME = HOME_DEF,
  parameter angle_t STEP = 32'h0000_8000,
  parameter int TICK_DIV = 50000
) (
  input logic clk,
  input logic rst,
  arm_joint_ctrl_if.slave bus
);
  logic valid_q, clamped_q, load, load_inv, tick;
  logic [N_JOINTS*W-1:0] target_q, target_d, angles;
  logic [N_JOINTS-1:0] at_tgt, clip;
  state_e state_q, state_d;
  assign load_inv = bus.en_inv && bus.inv_valid && !valid_q;
  assign load = bus.en_set || load_inv;
`ifdef ARM_SLEW_EN
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam angle_t STEP_EFF = STEP;
  logic [CW-1:0] cnt_q;
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  // Free-running tick divider, never restarted by a new target
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + 1'b1;
`else
  localparam angle_t STEP_EFF = '1;
  assign tick = 1'b1;
`endif
  for (genvar j = 0; j < N_JOINTS; j++) begin : g_j
    logic [W:0] c;
    assign c = clamp(bus.en_set ? bus.set_angles[j*W +: W] : bus.inv_angles[j*W +: W], ANG_MIN, ANG_MAX);
    assign clip[j] = c[W];
    assign target_d[j*W +: W] = load ? c[W-1:0] : target_q[j*W +: W];
    joint_slew #(.W(W), .HOME(HOME), .STEP(STEP_EFF)) u_slew (
      .clk(clk), .rst(rst), .tick_i(tick), .target_i(target_q[j*W +: W]),
      .angle_o(angles[j*W +: W]), .at_target_o(at_tgt[j])
    );
  end
  // Targets, valid edge history and sticky clamp flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      target_q <= {N_JOINTS{HOME}};
      valid_q <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      target_q <= target_d;
      valid_q <= bus.inv_valid;
      clamped_q <= clamped_q | (load & |clip);
    end
  // Controller state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // Move while any joint is off target, settle once all match
  always_comb begin
    state_d = state_q;
    state_d = &at_tgt ? IDLE : MOVE;
  end
  assign bus.angles = angles;
  assign bus.target = target_q;
  assign bus.moving = state_q == MOVE;
  assign bus.clamped = clamped_q;
endmodule

// File: tb/tb_arm_joint_ctrl.sv
// tb_arm_joint_ctrl: directed vector table plus multi-cycle sequences for arm_joint_ctrl
module tb_arm_joint_ctrl;
  localparam int N = 2, W = 32, TD = 4;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  typedef struct {logic es, ei, iv; logic [63:0] sa, ia, et; logic ec;} vec_t;
  vec_t tv[14];
  arm_joint_ctrl_if #(.N_JOINTS(N), .W(W)) bus();
  arm_joint_ctrl #(.N_JOINTS(N), .W(W), .STEP(32'h0000_8000), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] a2(int j1, int j0);
    return {32'(j1 * 65536), 32'(j0 * 65536)};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic wait_change(output int n);
    logic [63:0] p = bus.angles;
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.angles == p && n < 20);
    if (bus.angles == p) begin
      total++;
      bad++;
      $display("FAIL wait_change: got no angle change want change within 20 cycles");
    end
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic drive(logic es, logic [63:0] sa, logic ei, logic iv, logic [63:0] ia);
    bus.en_set = es;
    bus.set_angles = sa;
    bus.en_inv = ei;
    bus.inv_valid = iv;
    bus.inv_angles = ia;
  endtask
  initial begin
    int n;
    drive(0, 0, 0, 0, 0);
    tv[0]  = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, a2(90, 90), 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, a2(89, 91), 64'h0, a2(89, 91), 1'b0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 64'h0, a2(100, 100), a2(100, 100), 1'b0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 64'h0, a2(120, 120), a2(100, 100), 1'b0};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 64'h0, a2(120, 120), a2(100, 100), 1'b0};
    tv[5]  = '{1'b1, 1'b1, 1'b1, a2(80, 80), a2(110, 110), a2(80, 80), 1'b0};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 64'h0, a2(110, 110), a2(80, 80), 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, a2(80, 80), 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 64'h0, a2(70, 70), a2(80, 80), 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 64'h0, a2(70, 70), a2(80, 80), 1'b0};
    tv[10] = '{1'b0, 1'b1, 1'b1, 64'h0, a2(70, 70), a2(70, 70), 1'b0};
    tv[11] = '{1'b1, 1'b0, 1'b0, {32'hFFFF_0000, 32'h00C8_0000}, 64'h0, a2(180, 180), 1'b1};
    tv[12] = '{1'b1, 1'b0, 1'b0, a2(45, 135), 64'h0, a2(45, 135), 1'b1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, a2(45, 135), 1'b1};
    do_reset();
    chk("reset angles", bus.angles, a2(90, 90));
    chk("reset target", bus.target, a2(90, 90));
    chk("reset moving", 64'(bus.moving), 64'd0);
    chk("reset clamped", 64'(bus.clamped), 64'd0);
    for (int i = 0; i < 14; i++) begin
      drive(tv[i].es, tv[i].sa, tv[i].ei, tv[i].iv, tv[i].ia);
      cyc();
      chk($sformatf("vec%0d target", i), bus.target, tv[i].et);
      chk($sformatf("vec%0d clamped", i), 64'(bus.clamped), 64'(tv[i].ec));
    end
    drive(0, 0, 0, 0, 0);
    do_reset();
    chk("rst clears clamped", 64'(bus.clamped), 64'd0);
    drive(1, a2(89, 91), 0, 0, 0);
    cyc();
    chk("move target", bus.target, a2(89, 91));
    drive(0, 0, 0, 0, 0);
`ifdef ARM_SLEW_EN
    wait_change(n);
    chk("move step1", bus.angles, {32'h0059_8000, 32'h005A_8000});
    chk("move step1 moving", 64'(bus.moving), 64'd1);
    wait_change(n);
    chk("move tick gap", 64'(n), 64'(TD));
    chk("move step2", bus.angles, a2(89, 91));
    chk("move step2 moving", 64'(bus.moving), 64'd1);
`else
    cyc();
    chk("move angles", bus.angles, a2(89, 91));
    chk("move moving", 64'(bus.moving), 64'd1);
`endif
    cyc();
    chk("move settled", 64'(bus.moving), 64'd0);
    do_reset();
    drive(1, a2(95, 95), 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
`ifdef ARM_SLEW_EN
    wait_change(n);
    chk("mid first", bus.angles, {32'h005A_8000, 32'h005A_8000});
    drive(1, a2(85, 85), 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("mid retarget", bus.target, a2(85, 85));
    wait_change(n);
    chk("mid reverse", bus.angles, a2(90, 90));
`else
    cyc();
    chk("mid first", bus.angles, a2(95, 95));
    drive(1, a2(85, 85), 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("mid retarget", bus.target, a2(85, 85));
    cyc();
    chk("mid reverse", bus.angles, a2(85, 85));
`endif
    drive(1, a2(200, 100), 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("pre-rst clamped", 64'(bus.clamped), 64'd1);
    cyc();
    chk("pre-rst moving", 64'(bus.moving), 64'd1);
    #2 rst = 1;
    #1;
    chk("async angles", bus.angles, a2(90, 90));
    chk("async target", bus.target, a2(90, 90));
    chk("async moving", 64'(bus.moving), 64'd0);
    chk("async clamped", 64'(bus.clamped), 64'd0);
    #3 rst = 0;
    repeat (3) cyc();
    chk("post-rst angles", bus.angles, a2(90, 90));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
